// File: rtl/rbb_wr_arbiter_if.sv
// Handshake bundle between the result batch buffers, the write arbiter and the
// host write-request channel.
interface rbb_wr_arbiter_if #(
    parameter int NUM_RBB        = 4,
    parameter int LINE_IDX_WIDTH = 8,
    parameter int DATA_WIDTH     = 512,
    parameter int ADDR_WIDTH     = 32
);
    logic [NUM_RBB-1:0]                rbb_req_valid;
    logic [NUM_RBB*LINE_IDX_WIDTH-1:0] rbb_req_line_idx;
    logic [NUM_RBB*DATA_WIDTH-1:0]     rbb_req_data;
    logic [NUM_RBB-1:0]                rbb_req_ack;
    logic                              wr_almfull;
    logic                              wr_req_valid;
    logic [ADDR_WIDTH-1:0]             wr_req_addr;
    logic [DATA_WIDTH-1:0]             wr_req_data;

    modport master (
        input  rbb_req_valid, rbb_req_line_idx, rbb_req_data, wr_almfull,
        output rbb_req_ack, wr_req_valid, wr_req_addr, wr_req_data
    );

    modport slave (
        output rbb_req_valid, rbb_req_line_idx, rbb_req_data, wr_almfull,
        input  rbb_req_ack, wr_req_valid, wr_req_addr, wr_req_data
    );
endinterface

// File: rtl/rbb_wr_arbiter.sv
// Round-robin arbiter granting whole result batches from NUM_RBB buffers onto
// the single host write-request channel, one line per two cycles at most.
module rbb_wr_arbiter #(
    parameter int NUM_RBB         = 4,
    parameter int LINE_IDX_WIDTH  = 8,
    parameter int DATA_WIDTH      = 512,
    parameter int ADDR_WIDTH      = 32,
    parameter int BATCH_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       cfg_enable,
    input  logic [ADDR_WIDTH-1:0]      cfg_base_addr,
    rbb_wr_arbiter_if.master           bus,
    output logic                       batch_done,
    output logic [3:0]                 batch_done_id,
    output logic [BATCH_CNT_WIDTH-1:0] batch_count,
    output logic                       seq_err
);
    localparam int GW  = (NUM_RBB > 1) ? $clog2(NUM_RBB) : 1;
    localparam int LIW = LINE_IDX_WIDTH;
    localparam logic [LIW-1:0] LAST_LINE = '1;

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t                     state_q, state_d;
    logic [GW-1:0]              rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]              grant_q, grant_d;
    logic [LIW-1:0]             line_cnt_q, line_cnt_d;
    logic                       settle_q, settle_d;
    logic                       wr_valid_q, wr_valid_d;
    logic [ADDR_WIDTH-1:0]      wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]      wr_data_q, wr_data_d;
    logic [3:0]                 done_id_q, done_id_d;
    logic [BATCH_CNT_WIDTH-1:0] batch_cnt_q, batch_cnt_d;
    logic                       seq_err_q, seq_err_d;

    logic                       found;
    logic [GW-1:0]              pick;
    int unsigned                cand;
    logic                       issue;
    logic [LIW-1:0]             cur_idx;
    logic [DATA_WIDTH-1:0]      cur_data;

    // First requester at or after rr_ptr, wrapping modulo NUM_RBB.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = 0;
        for (int unsigned i = 0; i < NUM_RBB; i++) begin
            cand = 32'(rr_ptr_q) + i;
            if (cand >= 32'(NUM_RBB)) cand = cand - 32'(NUM_RBB);
            if (!found && bus.rbb_req_valid[cand]) begin
                found = 1'b1;
                pick  = GW'(cand);
            end
        end
    end

    assign cur_idx  = bus.rbb_req_line_idx[grant_q*LIW +: LIW];
    assign cur_data = bus.rbb_req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        line_cnt_d  = line_cnt_q;
        settle_d    = settle_q;
        wr_valid_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        done_id_d   = done_id_q;
        batch_cnt_d = batch_cnt_q;
        seq_err_d   = seq_err_q;
        bus.rbb_req_ack = '0;

        issue = (state_q == XFER) && !settle_q && bus.rbb_req_valid[grant_q] && !bus.wr_almfull;

        case (state_q)
            IDLE: begin
                if (cfg_enable && found) begin
                    grant_d    = pick;
                    line_cnt_d = '0;
                    settle_d   = 1'b1;
                    state_d    = XFER;
                end
            end
            XFER: begin
                settle_d = 1'b0;
                if (issue) begin
                    bus.rbb_req_ack[grant_q] = 1'b1;
                    // Buffer needs a cycle after ack to present its next line.
                    settle_d   = 1'b1;
                    wr_valid_d = 1'b1;
                    wr_addr_d  = cfg_base_addr + ADDR_WIDTH'({batch_cnt_q, cur_idx});
                    wr_data_d  = cur_data;
                    line_cnt_d = line_cnt_q + 1'b1;
                    if (cur_idx != line_cnt_q) seq_err_d = 1'b1;
                    if (line_cnt_q == LAST_LINE) begin
                        state_d   = DONE;
                        done_id_d = 4'(grant_q);
                    end
                end
            end
            DONE: begin
                batch_cnt_d = batch_cnt_q + 1'b1;
                if (grant_q == GW'(NUM_RBB - 1)) rr_ptr_d = '0;
                else                             rr_ptr_d = grant_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            line_cnt_q  <= '0;
            settle_q    <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_id_q   <= '0;
            batch_cnt_q <= '0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            line_cnt_q  <= line_cnt_d;
            settle_q    <= settle_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            done_id_q   <= done_id_d;
            batch_cnt_q <= batch_cnt_d;
            seq_err_q   <= seq_err_d;
        end
    end

    assign bus.wr_req_valid = wr_valid_q;
    assign bus.wr_req_addr  = wr_addr_q;
    assign bus.wr_req_data  = wr_data_q;
    assign batch_done       = (state_q == DONE);
    assign batch_done_id    = done_id_q;
    assign batch_count      = batch_cnt_q;
    assign seq_err          = seq_err_q;
endmodule

// File: tb/tb_rbb_wr_arbiter.sv
// Bench for rbb_wr_arbiter: emulated result buffers, a batch-level scoreboard
// of expected host writes, and directed plus randomized scenarios.
module tb_rbb_wr_arbiter;
    localparam int NR  = 4;
    localparam int LIW = 2;
    localparam int NL  = 4;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int BCW = 16;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           cfg_enable = 1'b0;
    logic [AW-1:0]  cfg_base_addr = '0;
    logic           batch_done;
    logic [3:0]     batch_done_id;
    logic [BCW-1:0] batch_count;
    logic           seq_err;

    rbb_wr_arbiter_if #(.NUM_RBB(NR), .LINE_IDX_WIDTH(LIW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    rbb_wr_arbiter #(.NUM_RBB(NR), .LINE_IDX_WIDTH(LIW), .DATA_WIDTH(DW),
                     .ADDR_WIDTH(AW), .BATCH_CNT_WIDTH(BCW)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_enable(cfg_enable), .cfg_base_addr(cfg_base_addr),
        .bus(bus.master), .batch_done(batch_done), .batch_done_id(batch_done_id),
        .batch_count(batch_count), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Emulated buffers: queued lines, front entry is what the buffer presents.
    logic [DW-1:0]  bdat [NR][$];
    logic [LIW-1:0] bidx [NR][$];
    int             nline [NR];
    logic [NR-1:0]  ack_seen = '0;
    bit gap_en = 0, af_rand_en = 0, force_af = 0;

    // Scoreboard model: per-buffer batch contents and expected write stream.
    logic [DW-1:0]  mdat [NR][$];
    logic [LIW-1:0] midx [NR][$];
    int             pend [NR];
    int unsigned    mptr = 0, mcount = 0;
    bit             msticky = 0;
    logic [AW-1:0]  exp_addr [$];
    logic [DW-1:0]  exp_data [$];
    bit             exp_serr [$];
    int             exp_done_id [$];
    int unsigned    exp_done_cnt [$];

    // Monitor statistics.
    int beats = 0, acks_total = 0, cyc = 0, last_ack = -1;
    int ack_cnt [NR];
    int ack_gaps [$];
    bit prev_ack = 0;

    initial begin
        for (int i = 0; i < NR; i++) begin nline[i] = 0; ack_cnt[i] = 0; pend[i] = 0; end
        bus.rbb_req_valid = '0;
        bus.rbb_req_line_idx = '0;
        bus.rbb_req_data = '0;
        bus.wr_almfull = 1'b0;
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NR; i++) begin
            if (ack_seen[i] && bdat[i].size() > 0) begin
                void'(bdat[i].pop_front());
                void'(bidx[i].pop_front());
                nline[i]++;
            end
        end
        ack_seen = '0;
        for (int i = 0; i < NR; i++) begin
            bit has;
            has = bdat[i].size() > 0;
            bus.rbb_req_valid[i] = has && !(gap_en && (nline[i] % NL != 0) && $urandom_range(0, 3) == 0);
            bus.rbb_req_line_idx[i*LIW +: LIW] = has ? bidx[i][0] : '0;
            bus.rbb_req_data[i*DW +: DW]       = has ? bdat[i][0] : '0;
        end
        bus.wr_almfull = force_af || (af_rand_en && $urandom_range(0, 3) == 0);
    end

    always @(negedge clk) begin
        cyc++;
        ack_seen = bus.rbb_req_ack;
        if (reset_n) begin
            chk("ack_onehot0", 64'($onehot0(bus.rbb_req_ack)), 1);
            if (|bus.rbb_req_ack) begin
                chk("ack_during_almfull", bus.wr_almfull, 0);
                chk("ack_back_to_back", prev_ack, 0);
                acks_total++;
                for (int i = 0; i < NR; i++) ack_cnt[i] += int'(bus.rbb_req_ack[i]);
                if (last_ack >= 0) ack_gaps.push_back(cyc - last_ack);
                last_ack = cyc;
            end
            prev_ack = |bus.rbb_req_ack;
            if (bus.wr_req_valid) begin
                beats++;
                chk("beat_expected", exp_addr.size() != 0, 1);
                if (exp_addr.size() != 0) begin
                    chk("wr_addr", bus.wr_req_addr, exp_addr.pop_front());
                    chk("wr_data", bus.wr_req_data, exp_data.pop_front());
                    chk("seq_err", seq_err, exp_serr.pop_front());
                end
            end
            if (batch_done) begin
                chk("done_expected", exp_done_id.size() != 0, 1);
                if (exp_done_id.size() != 0) begin
                    chk("done_id", batch_done_id, exp_done_id.pop_front());
                    chk("done_count", batch_count, exp_done_cnt.pop_front());
                end
            end
        end else begin
            prev_ack = 0;
            last_ack = -1;
        end
    end

    task automatic load_batch(input int b, input bit bad_seq);
        logic [LIW-1:0] idx;
        logic [DW-1:0]  d;
        for (int l = 0; l < NL; l++) begin
            idx = LIW'(l);
            if (bad_seq && l == 2) idx = 2'd3;
            if (bad_seq && l == 3) idx = 2'd2;
            d = $urandom;
            bdat[b].push_back(d); bidx[b].push_back(idx);
            mdat[b].push_back(d); midx[b].push_back(idx);
        end
        pend[b]++;
    endtask

    task automatic expect_batch(input int b);
        logic [LIW-1:0] idx;
        for (int l = 0; l < NL; l++) begin
            idx = midx[b].pop_front();
            exp_addr.push_back(cfg_base_addr + AW'(((mcount % 65536) * NL) + 32'(idx)));
            exp_data.push_back(mdat[b].pop_front());
            if (int'(idx) != l) msticky = 1;
            exp_serr.push_back(msticky);
        end
        exp_done_id.push_back(b);
        exp_done_cnt.push_back(mcount % 65536);
        mcount++;
        mptr = (b + 1) % NR;
        pend[b]--;
    endtask

    task automatic plan_rr();
        bit any;
        do begin
            any = 0;
            for (int k = 0; k < NR && !any; k++) begin
                int b;
                b = (int'(mptr) + k) % NR;
                if (pend[b] > 0) begin any = 1; expect_batch(b); end
            end
        end while (any);
    endtask

    task automatic mreset();
        mptr = 0; mcount = 0; msticky = 0;
        exp_addr.delete(); exp_data.delete(); exp_serr.delete();
        exp_done_id.delete(); exp_done_cnt.delete();
        for (int i = 0; i < NR; i++) begin
            bdat[i].delete(); bidx[i].delete(); mdat[i].delete(); midx[i].delete();
            nline[i] = 0; pend[i] = 0;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ack"}, bus.rbb_req_ack, 0);
        chk({tag, "_wr_valid"}, bus.wr_req_valid, 0);
        chk({tag, "_wr_addr"}, bus.wr_req_addr, 0);
        chk({tag, "_wr_data"}, bus.wr_req_data, 0);
        chk({tag, "_done"}, batch_done, 0);
        chk({tag, "_done_id"}, batch_done_id, 0);
        chk({tag, "_count"}, batch_count, 0);
        chk({tag, "_seq_err"}, seq_err, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 0;
        mreset();
        repeat (3) @(posedge clk);
        #2 check_zero("reset");
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((exp_addr.size() != 0 || exp_done_id.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk({tag, "_drain_lines_left"}, exp_addr.size(), 0);
        repeat (4) @(posedge clk);
    endtask

    task automatic wait_beats(input string tag, input int target, input int budget);
        int n = 0;
        while (beats < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk({tag, "_beat_wait"}, beats >= target, 1);
    endtask

    int b0, a0, c0;

    initial begin
        do_reset();

        // Single requester: buffer 2, base 0x1000.
        cfg_base_addr = 32'h1000;
        cfg_enable = 1;
        @(posedge clk);
        a0 = acks_total; ack_gaps.delete();
        load_batch(2, 0);
        plan_rr();
        wait_drain("single", 200);
        chk("single_acks_buf2", ack_cnt[2], 4);
        chk("single_acks_total", acks_total - a0, 4);
        chk("single_gap_count", ack_gaps.size(), 3);
        while (ack_gaps.size() != 0) chk("single_ack_gap", ack_gaps.pop_front(), 2);
        chk("single_batch_count", batch_count, 1);

        // All four buffers, two batches each: order 0,1,2,3,0,1,2,3.
        do_reset();
        cfg_base_addr = 32'h2000;
        @(posedge clk);
        for (int r = 0; r < 2; r++) for (int b = 0; b < NR; b++) load_batch(b, 0);
        plan_rr();
        wait_drain("all4", 400);
        chk("all4_batch_count", batch_count, 8);

        // Randomized rounds with almfull noise and buffer valid gaps.
        gap_en = 1; af_rand_en = 1;
        for (int round = 0; round < 8; round++) begin
            @(posedge clk);
            cfg_base_addr = $urandom;
            for (int b = 0; b < NR; b++) begin
                int k;
                k = $urandom_range(0, 2);
                for (int j = 0; j < k; j++) load_batch(b, 0);
            end
            plan_rr();
            wait_drain("rand", 3000);
        end
        gap_en = 0; af_rand_en = 0;

        // almfull held for 10 cycles mid-batch.
        @(posedge clk);
        cfg_base_addr = 32'h3000;
        b0 = beats;
        load_batch(1, 0);
        plan_rr();
        wait_beats("stall", b0 + 2, 200);
        force_af = 1;
        a0 = acks_total;
        @(posedge clk);
        c0 = beats;
        repeat (9) @(posedge clk);
        chk("stall_no_beats", beats - c0, 0);
        chk("stall_no_acks", acks_total - a0, 0);
        force_af = 0;
        wait_drain("stall", 200);
        chk("stall_total_beats", beats - b0, 4);

        // Out-of-order line indices 0,1,3,2 then a clean batch.
        do_reset();
        cfg_base_addr = 32'h4000;
        @(posedge clk);
        b0 = beats;
        load_batch(3, 1);
        load_batch(0, 0);
        plan_rr();
        wait_drain("seq", 300);
        chk("seq_beats", beats - b0, 8);
        chk("seq_err_sticky", seq_err, 1);
        chk("seq_batch_count", batch_count, 2);

        // Asynchronous reset during line 1, then restart from buffer 0.
        do_reset();
        cfg_base_addr = 32'h5000;
        @(posedge clk);
        b0 = beats;
        load_batch(2, 0);
        plan_rr();
        wait_beats("midrst", b0 + 1, 100);
        #2 reset_n = 0;
        #1 check_zero("midrst");
        mreset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        load_batch(2, 0);
        load_batch(0, 0);
        plan_rr();
        wait_drain("midrst", 300);
        chk("midrst_batch_count", batch_count, 2);

        // Enable dropped while buffer 1 is mid-batch, buffer 3 waiting.
        @(posedge clk);
        cfg_base_addr = 32'h6000;
        b0 = beats;
        c0 = ack_cnt[3];
        load_batch(1, 0);
        expect_batch(1);
        wait_beats("endrop", b0 + 1, 100);
        cfg_enable = 0;
        load_batch(3, 0);
        wait_drain("endrop", 200);
        repeat (20) @(posedge clk);
        chk("endrop_buf1_beats", beats - b0, 4);
        chk("endrop_buf3_held", ack_cnt[3] - c0, 0);
        chk("endrop_batch_count", batch_count, 3);
        expect_batch(3);
        cfg_enable = 1;
        wait_drain("reenable", 200);
        chk("reenable_buf3_acks", ack_cnt[3] - c0, 4);
        chk("reenable_batch_count", batch_count, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rbb_wr_arbiter.md
Name: rbb_wr_arbiter

Overview:
- Shares the single host write-request channel among NUM_RBB result batch buffers, one per PE array.
- Grants a whole result batch (2^LINE_IDX_WIDTH lines) to one buffer at a time, round-robin.
- Drains the granted batch line by line using the buffer's ReqValid/ReqLineIdx/ReqAck handshake.
- Forms the host line address from a configured base, a running batch counter and the line index.

Parameters:
- NUM_RBB, 4, number of result batch buffers arbitrated (2..16).
- LINE_IDX_WIDTH, 8, line index width; batch length is NUM_LINES = 2^LINE_IDX_WIDTH.
- DATA_WIDTH, 512, result line width.
- ADDR_WIDTH, 32, host cache-line address width.
- BATCH_CNT_WIDTH, 16, width of the completed-batch counter.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- cfg_enable  in  1  permits new grants
- cfg_base_addr  in  ADDR_WIDTH  host line address of the result region
- rbb_req_valid  in  NUM_RBB  per-buffer ReqValid
- rbb_req_line_idx  in  NUM_RBB*LINE_IDX_WIDTH  per-buffer ReqLineIdx; buffer i occupies slice i
- rbb_req_data  in  NUM_RBB*DATA_WIDTH  per-buffer RdDout; buffer i occupies slice i
- rbb_req_ack  out  NUM_RBB  per-buffer ReqAck, one-hot or zero
- wr_almfull  in  1  host write channel almost full
- wr_req_valid  out  1  write request strobe
- wr_req_addr  out  ADDR_WIDTH  write line address
- wr_req_data  out  DATA_WIDTH  write line data
- batch_done  out  1  one-cycle pulse when a batch's last line issues
- batch_done_id  out  4  index of the buffer that completed
- batch_count  out  BATCH_CNT_WIDTH  number of completed batches
- seq_err  out  1  sticky line-order error

Behaviour:
- Reset (asynchronous, reset_n low):
  - state IDLE; rr_ptr=0; line counter=0; settle=0.
  - All outputs 0: rbb_req_ack, wr_req_valid, wr_req_addr, wr_req_data, batch_done, batch_done_id, batch_count, seq_err.
  - Reset mid-batch abandons the batch; no further ack is issued.
- IDLE:
  - If cfg_enable and any rbb_req_valid: grant the first requester found searching from rr_ptr upward, wrapping modulo NUM_RBB. Go to XFER with line counter=0 and settle=1.
  - Otherwise remain in IDLE.
- XFER, issue condition: settle==0, rbb_req_valid[grant] high and wr_almfull low.
- XFER, on issue in cycle T:
  - rbb_req_ack[grant]=1 combinationally in T; no other ack bit is ever high.
  - In T+1, registered: wr_req_valid=1; wr_req_data = rbb_req_data[grant] sampled in T.
  - wr_req_addr = cfg_base_addr + {batch_count, line_idx}, zero-extended and truncated to ADDR_WIDTH (wraps).
  - settle=1 for T+1, so there is no issue in T+1: the buffer presents its next line one cycle after ack. Maximum rate is therefore one line per 2 cycles.
  - Line counter increments.
- Line-order check: if rbb_req_line_idx[grant] != line counter at issue, set seq_err (sticky until reset). The line still issues, using the presented index.
- Stalls: wr_almfull high, or rbb_req_valid[grant] low, means no issue and the state is held; grant is never revoked mid-batch. Downstream must absorb at least 2 writes after asserting almfull.
- Last line: issue when line counter==NUM_LINES-1 moves to DONE.
- DONE, one cycle:
  - batch_done=1 and batch_done_id=grant.
  - batch_count increments, wrapping at 2^BATCH_CNT_WIDTH.
  - rr_ptr = grant+1 mod NUM_RBB.
  - Go to IDLE. A new grant earliest in the cycle after DONE.
- cfg_enable deasserted during XFER: the current batch completes; no new grant afterwards.
- cfg_base_addr is sampled every issue; software holds it stable while enabled.

Test Plan:
- Single requester, LINE_IDX_WIDTH=2, base=0x1000, buffer 2 valid with idx 0..3:
  - exactly 4 acks to bit 2, spaced 2 cycles apart;
  - addrs 0x1000..0x1003;
  - batch_done pulses once with id=2; batch_count=1.
- All 4 buffers valid continuously -> grant order 0,1,2,3,0; second batch of buffer 0 uses addrs base+16..base+19 (batch_count=4 with LINE_IDX_WIDTH=2).
- wr_almfull held high for 10 cycles mid-batch -> no ack and no wr_req_valid during the stall; resumes at the same line; data matches.
- Buffer presents idx 0,1,3,... -> seq_err=1 on the third issue and stays 1; batch still completes with 4 lines.
- reset_n asserted asynchronously during line 1 -> all outputs 0 immediately; after release, a new grant starts at buffer 0 with line counter 0.
- cfg_enable dropped while buffer 1 mid-batch, buffer 3 valid -> buffer 1 finishes; buffer 3 not granted until cfg_enable=1.
